// File: rtl/pong_pkg.sv
// Shared types, default raster timing and the overflow-safe box test used by
// the Pong frame renderer.
package pong_pkg;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } pong_xy_t;

  typedef enum logic [1:0] {
    KIND_BG     = 2'd0,
    KIND_NET    = 2'd1,
    KIND_PADDLE = 2'd2,
    KIND_BALL   = 2'd3
  } pixel_kind_e;

  localparam int unsigned DEF_H_ACTIVE  = 640;
  localparam int unsigned DEF_H_FP      = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BP      = 48;
  localparam int unsigned DEF_V_ACTIVE  = 480;
  localparam int unsigned DEF_V_FP      = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BP      = 33;
  localparam int unsigned DEF_BALL_SIZE = 8;
  localparam int unsigned DEF_PADDLE_W  = 8;
  localparam int unsigned DEF_PADDLE_H  = 64;

  // 17-bit sums keep an object parked near 65535 from wrapping onto column/row 0.
  function automatic logic in_box(input logic [15:0] px, input logic [15:0] py,
                                  input logic [15:0] bx, input logic [15:0] by,
                                  input logic [16:0] w,  input logic [16:0] h);
    return ({1'b0, px} >= {1'b0, bx}) && ({1'b0, px} < ({1'b0, bx} + w)) &&
           ({1'b0, py} >= {1'b0, by}) && ({1'b0, py} < ({1'b0, by} + h));
  endfunction

endpackage

// File: rtl/pong_raster_timing.sv
// Pixel/line counters with registered sync, data-enable, coordinates and a
// frame-start pulse, all delayed one pix_en tick behind the counters.
module pong_raster_timing
  import pong_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  output logic [15:0] h_cnt_o,
  output logic [15:0] v_cnt_o,
  output logic        wrap_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic        frame_start_o,
  output logic [15:0] pixel_x_o,
  output logic [15:0] pixel_y_o
);

  localparam logic [15:0] H_LAST   = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] V_LAST   = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [15:0] H_ACT_L  = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT_L  = 16'(V_ACTIVE);
  localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);

  logic [15:0] h_cnt_q, h_cnt_d;
  logic [15:0] v_cnt_q, v_cnt_d;
  logic        h_last, v_last;
  logic        hsync_q, vsync_q, de_q, frame_start_q;
  logic [15:0] pixel_x_q, pixel_y_q;

  assign h_last = (h_cnt_q == H_LAST);
  assign v_last = (v_cnt_q == V_LAST);

  always_comb begin
    h_cnt_d = h_last ? 16'd0 : h_cnt_q + 16'd1;
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      v_cnt_d = v_last ? 16'd0 : v_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q       <= 16'd0;
      v_cnt_q       <= 16'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      pixel_x_q     <= 16'd0;
      pixel_y_q     <= 16'd0;
    end else begin
      // Pulse lasts one clock even when pix_en is slower than clk.
      frame_start_q <= 1'b0;
      if (pix_en) begin
        h_cnt_q       <= h_cnt_d;
        v_cnt_q       <= v_cnt_d;
        hsync_q       <= !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
        vsync_q       <= !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
        de_q          <= (h_cnt_q < H_ACT_L) && (v_cnt_q < V_ACT_L);
        frame_start_q <= (h_cnt_q == 16'd0) && (v_cnt_q == 16'd0);
        pixel_x_q     <= h_cnt_q;
        pixel_y_q     <= v_cnt_q;
      end
    end
  end

  assign h_cnt_o       = h_cnt_q;
  assign v_cnt_o       = v_cnt_q;
  assign wrap_o        = pix_en && h_last && v_last;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign de_o          = de_q;
  assign frame_start_o = frame_start_q;
  assign pixel_x_o     = pixel_x_q;
  assign pixel_y_o     = pixel_y_q;

endmodule

// File: rtl/pong_frame_renderer.sv
// Pong playfield renderer: blanking-only state handshake, shadow/active double
// buffer committed at frame wrap, and per-pixel ball/paddle/net classification.
module pong_frame_renderer
  import pong_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP,
  parameter int unsigned BALL_SIZE = DEF_BALL_SIZE,
  parameter int unsigned PADDLE_W  = DEF_PADDLE_W,
  parameter int unsigned PADDLE_H  = DEF_PADDLE_H
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        state_valid,
  output logic        state_ready,
  input  logic [31:0] ball_pos,
  input  logic [31:0] left_paddle_pos,
  input  logic [31:0] right_paddle_pos,
  input  logic [15:0] score,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [15:0] pixel_x,
  output logic [15:0] pixel_y,
  output logic [1:0]  pixel_kind,
  output logic        frame_start,
  output logic [15:0] score_out
);

  localparam logic [15:0] H_ACT_L = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT_L = 16'(V_ACTIVE);
  localparam logic [15:0] NET_X   = 16'(H_ACTIVE / 2);
  localparam logic [16:0] BALL_L  = 17'(BALL_SIZE);
  localparam logic [16:0] PAD_W_L = 17'(PADDLE_W);
  localparam logic [16:0] PAD_H_L = 17'(PADDLE_H);

  logic [15:0] h_cnt, v_cnt;
  logic        wrap;
  logic        xfer;

  pong_xy_t    sh_ball_q, sh_ball_d, sh_lp_q, sh_lp_d, sh_rp_q, sh_rp_d;
  pong_xy_t    act_ball_q, act_ball_d, act_lp_q, act_lp_d, act_rp_q, act_rp_d;
  logic [15:0] sh_score_q, sh_score_d, act_score_q, act_score_d;
  pixel_kind_e kind_q, kind_d;

  pong_raster_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk          (clk),
    .rst          (rst),
    .pix_en       (pix_en),
    .h_cnt_o      (h_cnt),
    .v_cnt_o      (v_cnt),
    .wrap_o       (wrap),
    .hsync_o      (hsync),
    .vsync_o      (vsync),
    .de_o         (de),
    .frame_start_o(frame_start),
    .pixel_x_o    (pixel_x),
    .pixel_y_o    (pixel_y)
  );

  assign state_ready = !rst && (v_cnt >= V_ACT_L);
  assign xfer        = state_valid && state_ready;

  // Active copies from the shadow's next value so a transfer on the wrap edge lands in the new frame.
  always_comb begin
    sh_ball_d   = xfer ? pong_xy_t'(ball_pos)         : sh_ball_q;
    sh_lp_d     = xfer ? pong_xy_t'(left_paddle_pos)  : sh_lp_q;
    sh_rp_d     = xfer ? pong_xy_t'(right_paddle_pos) : sh_rp_q;
    sh_score_d  = xfer ? score                        : sh_score_q;
    act_ball_d  = wrap ? sh_ball_d  : act_ball_q;
    act_lp_d    = wrap ? sh_lp_d    : act_lp_q;
    act_rp_d    = wrap ? sh_rp_d    : act_rp_q;
    act_score_d = wrap ? sh_score_d : act_score_q;
  end

  always_comb begin
    kind_d = KIND_BG;
    if ((h_cnt < H_ACT_L) && (v_cnt < V_ACT_L)) begin
      if (in_box(h_cnt, v_cnt, act_ball_q.x, act_ball_q.y, BALL_L, BALL_L)) begin
        kind_d = KIND_BALL;
      end else if (in_box(h_cnt, v_cnt, act_lp_q.x, act_lp_q.y, PAD_W_L, PAD_H_L) ||
                   in_box(h_cnt, v_cnt, act_rp_q.x, act_rp_q.y, PAD_W_L, PAD_H_L)) begin
        kind_d = KIND_PADDLE;
      end else if ((h_cnt == NET_X) && !v_cnt[3]) begin
        kind_d = KIND_NET;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_ball_q   <= '0;
      sh_lp_q     <= '0;
      sh_rp_q     <= '0;
      sh_score_q  <= '0;
      act_ball_q  <= '0;
      act_lp_q    <= '0;
      act_rp_q    <= '0;
      act_score_q <= '0;
      kind_q      <= KIND_BG;
    end else begin
      sh_ball_q   <= sh_ball_d;
      sh_lp_q     <= sh_lp_d;
      sh_rp_q     <= sh_rp_d;
      sh_score_q  <= sh_score_d;
      act_ball_q  <= act_ball_d;
      act_lp_q    <= act_lp_d;
      act_rp_q    <= act_rp_d;
      act_score_q <= act_score_d;
      if (pix_en) begin
        kind_q <= kind_d;
      end
    end
  end

  assign pixel_kind = kind_q;
  assign score_out  = act_score_q;

endmodule

// File: tb/tb_pong_frame_renderer.sv
// Self-checking bench for pong_frame_renderer on a shrunken raster, using a
// pixel-index reference model plus directed probe pixels.
module tb_pong_frame_renderer;

  localparam int HA = 40, HF = 4, HS = 8, HB = 4;
  localparam int VA = 30, VF = 2, VS = 2, VB = 3;
  localparam int BS = 8, PW = 4, PH = 12;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam logic [53:0] RST_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 16'd0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b0;
  logic        state_valid = 1'b0;
  logic        state_ready;
  logic [31:0] ball_pos = '0, left_paddle_pos = '0, right_paddle_pos = '0;
  logic [15:0] score = '0;
  logic        hsync, vsync, de, frame_start;
  logic [15:0] pixel_x, pixel_y, score_out;
  logic [1:0]  pixel_kind;

  always #5 clk = ~clk;

  pong_frame_renderer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .BALL_SIZE(BS), .PADDLE_W(PW), .PADDLE_H(PH)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .state_valid(state_valid), .state_ready(state_ready),
    .ball_pos(ball_pos), .left_paddle_pos(left_paddle_pos),
    .right_paddle_pos(right_paddle_pos), .score(score),
    .hsync(hsync), .vsync(vsync), .de(de),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_kind(pixel_kind),
    .frame_start(frame_start), .score_out(score_out)
  );

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a linear tick index over the frame plus shadow/active state.
  int          m_idx;
  logic [31:0] s_ball, s_lp, s_rp, a_ball, a_lp, a_rp;
  logic [15:0] s_score, a_score;
  logic        e_hs, e_vs, e_de, e_fs;
  logic [1:0]  e_kind;
  logic [15:0] e_px, e_py, e_score;

  function automatic int m_h();
    return m_idx % HT;
  endfunction

  function automatic int m_v();
    return m_idx / HT;
  endfunction

  function automatic bit inb(int x, int y, logic [31:0] p, int w, int h);
    int bx, by;
    bx = int'(p[31:16]);
    by = int'(p[15:0]);
    return (x >= bx) && (x < bx + w) && (y >= by) && (y < by + h);
  endfunction

  function automatic int kind_of(int x, int y);
    if (inb(x, y, a_ball, BS, BS)) return 3;
    if (inb(x, y, a_lp, PW, PH) || inb(x, y, a_rp, PW, PH)) return 2;
    if (x == HA / 2 && (y % 16) < 8) return 1;
    return 0;
  endfunction

  task automatic reset_model();
    m_idx = 0;
    s_ball = '0; s_lp = '0; s_rp = '0; s_score = '0;
    a_ball = '0; a_lp = '0; a_rp = '0; a_score = '0;
    e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0;
    e_kind = 2'd0; e_px = '0; e_py = '0; e_score = '0;
  endtask

  task automatic model_tick(input bit pen, input bit sv);
    int h, v;
    h = m_h();
    v = m_v();
    if (sv && v >= VA) begin
      s_ball = ball_pos; s_lp = left_paddle_pos; s_rp = right_paddle_pos; s_score = score;
    end
    if (pen) begin
      e_hs   = !(h >= HA + HF && h < HA + HF + HS);
      e_vs   = !(v >= VA + VF && v < VA + VF + VS);
      e_de   = (h < HA) && (v < VA);
      e_kind = e_de ? 2'(kind_of(h, v)) : 2'd0;
      e_px   = 16'(h);
      e_py   = 16'(v);
      e_fs   = (m_idx == 0);
      if (m_idx == FR - 1) begin
        a_ball = s_ball; a_lp = s_lp; a_rp = s_rp; a_score = s_score;
      end
      m_idx = (m_idx + 1) % FR;
    end else begin
      e_fs = 1'b0;
    end
    e_score = a_score;
  endtask

  int cyc = 0, last_fs = -1, exp_period = 0, hits = 0;
  bit saw_fs = 0, armed = 0;
  int pr_x[$], pr_y[$], pr_k[$];

  task automatic step(input bit pen, input bit sv);
    pix_en = pen;
    state_valid = sv;
    #1;
    check("ready", state_ready, (m_v() >= VA));
    @(posedge clk);
    model_tick(pen, sv);
    @(negedge clk);
    cyc++;
    check("outs", {hsync, vsync, de, frame_start, pixel_kind, pixel_x, pixel_y, score_out},
          {e_hs, e_vs, e_de, e_fs, e_kind, e_px, e_py, e_score});
    if (frame_start) begin
      saw_fs = 1;
      if (exp_period != 0 && last_fs >= 0) check("fs_period", cyc - last_fs, exp_period);
      last_fs = cyc;
    end
    if (armed && de) begin
      for (int i = 0; i < pr_x.size(); i++) begin
        if (int'(pixel_x) == pr_x[i] && int'(pixel_y) == pr_y[i]) begin
          check("probe", pixel_kind, pr_k[i]);
          hits++;
        end
      end
    end
  endtask

  task automatic add_probe(input int x, input int y, input int k);
    pr_x.push_back(x); pr_y.push_back(y); pr_k.push_back(k);
  endtask

  task automatic probe_phase(input logic [31:0] b, input logic [31:0] l, input logic [31:0] r,
                             input logic [15:0] s);
    ball_pos = b; left_paddle_pos = l; right_paddle_pos = r; score = s;
    armed = 0;
    for (int i = 0; i < FR; i++) step(1'b1, 1'b1);
    hits = 0;
    armed = 1;
    for (int i = 0; i < FR; i++) step(1'b1, 1'b0);
    armed = 0;
    check("probe_hits", hits, pr_x.size());
    check("probe_score", score_out, s);
    pr_x.delete(); pr_y.delete(); pr_k.delete();
  endtask

  function automatic logic [31:0] rand_pos(input int xmax, input int ymax);
    logic [15:0] x, y;
    x = ($urandom_range(0, 9) == 0) ? 16'(65528 + $urandom_range(0, 7)) : 16'($urandom_range(0, xmax));
    y = ($urandom_range(0, 9) == 0) ? 16'(65528 + $urandom_range(0, 7)) : 16'($urandom_range(0, ymax));
    return {x, y};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    reset_model();
    repeat (2) @(negedge clk);
    check("rst_ready_held", state_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_outs", {hsync, vsync, de, frame_start, pixel_kind, pixel_x, pixel_y, score_out}, RST_VEC);
    @(negedge clk);

    // Ball, paddles and net on a clean field.
    exp_period = FR;
    last_fs = -1;
    add_probe(10, 5, 3);  add_probe(17, 12, 3); add_probe(18, 5, 0);  add_probe(9, 5, 0);
    add_probe(20, 0, 1);  add_probe(20, 8, 0);  add_probe(20, 16, 1);
    add_probe(2, 10, 2);  add_probe(5, 21, 2);  add_probe(6, 10, 0);  add_probe(5, 22, 0);
    add_probe(33, 18, 2); add_probe(36, 29, 2); add_probe(37, 20, 0);
    probe_phase({16'd10, 16'd5}, {16'd2, 16'd10}, {16'd33, 16'd18}, 16'h1122);

    // Ball parked at x = 65530 must not wrap onto the left columns.
    add_probe(0, 0, 0); add_probe(1, 0, 0); add_probe(1, 7, 0); add_probe(0, 3, 0);
    probe_phase({16'd65530, 16'd0}, {16'd3, 16'd8}, {16'd33, 16'd18}, 16'h3344);

    // Ball overlapping the left paddle wins.
    add_probe(3, 12, 3); add_probe(2, 10, 2); add_probe(10, 19, 3); add_probe(11, 19, 0);
    add_probe(2, 21, 2); add_probe(5, 14, 3);
    probe_phase({16'd3, 16'd12}, {16'd2, 16'd10}, {16'd33, 16'd18}, 16'h5566);

    // Two transfers in one blanking period: the last one wins.
    guard = 0;
    while (m_v() < VA && guard < 2 * FR) begin step(1'b1, 1'b0); guard++; end
    check("reach_blank", guard < 2 * FR, 1'b1);
    score = 16'h0102; step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    score = 16'h0203; step(1'b1, 1'b1);
    saw_fs = 0; guard = 0;
    while (!saw_fs && guard < 2 * FR) begin step(1'b1, 1'b0); guard++; end
    check("fs_seen", saw_fs, 1'b1);
    check("score_2xfer", score_out, 16'h0203);

    // Transfer on the wrap edge itself reaches the new frame.
    guard = 0;
    while (m_idx != FR - 1 && guard < 2 * FR) begin step(1'b1, 1'b0); guard++; end
    score = 16'h0A0B;
    step(1'b1, 1'b1);
    check("score_wrap", score_out, 16'h0A0B);

    // Asynchronous reset in the middle of the active area.
    exp_period = 0;
    guard = 0;
    while (!(m_h() == 30 && m_v() == 20) && guard < 2 * FR) begin step(1'b1, 1'b0); guard++; end
    check("reach_mid", guard < 2 * FR, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_outs", {hsync, vsync, de, frame_start, pixel_kind, pixel_x, pixel_y, score_out}, RST_VEC);
    check("rst_mid_ready", state_ready, 1'b0);
    reset_model();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0);
    check("fs_after_rst", {frame_start, pixel_x, pixel_y}, {1'b1, 16'd0, 16'd0});

    // Half-rate pixel enable: frame period doubles, handshake still completes.
    exp_period = 2 * FR;
    last_fs = cyc;
    score = 16'h5A5A;
    ball_pos = {16'd12, 16'd12};
    for (int i = 0; i < 4 * FR + 10; i++) step(i % 2 == 1, 1'b1);
    check("toggle_score", score_out, 16'h5A5A);

    // Randomised traffic against the model.
    exp_period = 0;
    for (int i = 0; i < 3 * FR; i++) begin
      ball_pos = rand_pos(HA + 4, VA + 4);
      left_paddle_pos = rand_pos(HA + 4, VA + 4);
      right_paddle_pos = rand_pos(HA + 4, VA + 4);
      score = 16'($urandom);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pong_frame_renderer.md
Name: pong_frame_renderer

Overview:
- Read side of the game-state interface: consumes ball, paddle and score state produced by the game engine and draws the playfield on a raster display.
- Generates VGA-style timing (hsync/vsync/de), classifies every pixel (ball, paddle, net, background) and exposes a ready/valid port so the engine can write new state only during vertical blanking.
- State is double-buffered, so a frame never shows a mix of two game states.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- BALL_SIZE, 8, ball edge length in pixels
- PADDLE_W, 8, paddle width
- PADDLE_H, 64, paddle height

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- pix_en  in  1  pixel-rate enable; timing advances only when high
- state_valid  in  1  engine presents new state
- state_ready  out  1  renderer accepts state this cycle
- ball_pos  in  32  {x[31:16], y[15:0]}, top-left of ball
- left_paddle_pos  in  32  {x, y}, top-left of left paddle
- right_paddle_pos  in  32  {x, y}, top-left of right paddle
- score  in  16  {right[15:8], left[7:0]}, latched with state, passed through
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- de  out  1  data enable, high in the active area
- pixel_x  out  16  x coordinate of the current output pixel
- pixel_y  out  16  y coordinate of the current output pixel
- pixel_kind  out  2  0 = BG, 1 = NET, 2 = PADDLE, 3 = BALL
- frame_start  out  1  one-cycle pulse when the (0,0) pixel is output
- score_out  out  16  score belonging to the frame currently displayed

Behaviour:
- Reset (async, any time, including mid-frame):
  - h_cnt, v_cnt, shadow and active state registers all go to 0.
  - Outputs: hsync = 1, vsync = 1, de = 0, pixel_x = 0, pixel_y = 0, pixel_kind = BG, frame_start = 0, score_out = 0, state_ready = 0.
  - After release, the first pix_en tick outputs pixel (0,0) with frame_start = 1. No partial transfer survives reset.
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the four H_* parameters (800 by default). v_cnt runs 0..V_TOTAL-1 (525 by default).
  - On a tick where h_cnt wraps, v_cnt increments; both wrap to 0 together at end of frame.
  - Counters hold when pix_en = 0.
- Outputs:
  - All pixel outputs are registered on pix_en ticks and reflect the counter value from before the tick (latency 1 tick). Sync, de and kind are mutually aligned.
  - hsync = 0 iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync = 0 iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
  - de = (h < H_ACTIVE) && (v < V_ACTIVE). Outside de, pixel_kind = BG.
- Handshake:
  - state_ready = !rst && (v_cnt >= V_ACTIVE). It is driven combinationally from the counter register.
  - A transfer occurs on any clk edge with state_valid && state_ready, independent of pix_en. It overwrites the shadow registers (ball, paddles, score); the last transfer wins.
  - state_valid may be held high across the active region; it is accepted at the first blanking cycle.
- Commit:
  - On the pix_en tick where the counters wrap to (0,0), active <= shadow.
  - If a transfer happens on that same edge, active takes the incoming values (bypass), not the stale shadow.
- Hit test (active state, per pixel):
  - All comparisons use 17-bit arithmetic so that pos + size never wraps. A ball at x = 65530 must not light pixels 0..1.
  - BALL: bx <= x < bx+BALL_SIZE and by <= y < by+BALL_SIZE.
  - PADDLE: the same test against either paddle with PADDLE_W × PADDLE_H.
  - NET: x == H_ACTIVE/2 and y[3] == 0 (dashed line).
  - Priority: BALL > PADDLE > NET > BG.
- score_out updates only at commit.

Decomposition:
- Package pong_pkg:
  - pong_xy_t, a packed struct {x[15:0], y[15:0]} matching the 32-bit position convention.
  - pixel_kind_e enum (BG, NET, PADDLE, BALL).
  - Default timing constants.
- Sub-module pong_raster_timing: the counters, sync/de generation and wrap/frame_start detection.
- Top level: handshake, double buffer and hit test.

Test Plan:
- Reset mid-frame (rst asserted at h = 300, v = 200) -> all outputs at reset values immediately; first tick after release gives frame_start = 1, pixel (0,0).
- pix_en = 1 continuously -> frame_start pulses exactly 420000 clocks apart; hsync low for 96 consecutive ticks starting when pixel_x reports 656; vsync low for exactly 2 lines.
- ball_pos = {100, 50}, transferred in blanking -> next frame: BALL at x 100..107 and y 50..57; pixel (108,50) = BG; pixel (320,0) = NET; pixel (320,8) = BG.
- state_valid raised at v = 10 -> state_ready = 0 until v = 480; transfer happens at the first cycle with v = 480; the current frame is unchanged.
- Two transfers in one blanking period (score 0x0102, then 0x0203) -> score_out = 0x0203 after the next frame_start; a transfer on the wrap edge itself is visible in the new frame.
- Edge cases: ball x = 65530 draws nothing at x = 0..1; paddle overlapping ball reports BALL. With pix_en toggling 1/0, the frame period doubles to 840000 clocks and the handshake still completes.
